// File: rtl/score_bcd_if.sv
// score_bcd_if
// Request/result bundle between a score source and score_bcd_converter.
//   start  : conversion request (driven by master)
//   bin    : unsigned binary value to convert (driven by master)
//   busy   : conversion in progress (driven by slave)
//   done   : one-cycle pulse when digits/blank update (driven by slave)
//   digits : BCD result, digit k in bits [4k+3:4k] (driven by slave)
//   blank  : leading-zero flags, blank[0] always 0 (driven by slave)
interface score_bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, digits, blank);
  modport slave  (input start, bin, output busy, done, digits, blank);
endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Sequential shift-and-add-3 binary-to-BCD converter for the score display.
// One BIN_W-cycle conversion per request; digits/blank hold the last result
// until the edge that raises done.
//   clk   : clock, rising edge active
//   reset : asynchronous active-low reset
//   bus   : score_bcd_if slave modport (start/bin in, busy/done/digits/blank out)
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for start, result registers stable
// SHIFT | one add-3 + shift per cycle, BIN_W cycles
module score_bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  score_bcd_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sr, sr_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt, acc_adj, acc_sh;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [ACC_W-1:0]   digits_q, digits_nxt;
  logic [DIGITS-1:0]  blank_q, blank_nxt, blank_sh;
  logic               zero_hi;

  // Add-3 on the pre-shift accumulator, then the combined {acc,sr} shift.
  // blank_sh is derived from the shifted value so it matches the digits
  // captured on the final shift.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5)
        acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    acc_sh = {acc_adj[ACC_W-2:0], sr[BIN_W-1]};

    blank_sh = '0;
    zero_hi  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_hi     = zero_hi & (acc_sh[4*k +: 4] == 4'd0);
      blank_sh[k] = zero_hi;
    end
  end

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    digits_nxt = digits_q;
    blank_nxt  = blank_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sr_nxt    = bus.bin;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = acc_sh;
        sr_nxt  = sr << 1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          digits_nxt = acc_sh;
          blank_nxt  = blank_sh;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      digits_q <= digits_nxt;
      blank_q  <= blank_nxt;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign bus.blank  = blank_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter
// Directed and random checks of score_bcd_converter (BIN_W=16, DIGITS=5)
// against a decimal-arithmetic reference model.
module tb_score_bcd_converter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  score_bcd_if #(.BIN_W(16), .DIGITS(5)) bus ();

  score_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_digits(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit k (k>=1) is a leading zero exactly when the value is below 10^k.
  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] b;
    int p;
    b = '0;
    p = 10;
    for (int k = 1; k < 5; k++) begin
      b[k] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input int v);
    int n;
    int busy_n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'(v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 16'($urandom);
    n = 0;
    busy_n = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 16);
    check("busy_cycles", busy_n, 16);
    check("digits", bus.digits, ref_digits(v));
    check("blank", bus.blank, ref_blank(v));
    check("busy_at_done", bus.busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [19:0] cap;

    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_digits", bus.digits, 0);
    check("rst_blank", bus.blank, 5'b11110);
    @(negedge clk);
    reset = 1'b1;

    convert(0);
    convert(65535);
    convert(1234);
    convert(100);
    convert(7);
    convert(9);
    convert(10);
    convert(10000);
    convert(59999);

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd1234;
    @(posedge clk); #1;
    bus.bin = 16'd4321;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", n, 16);
    check("b2b_first_digits", bus.digits, 20'h01234);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!bus.done && n < 40) check("b2b_hold", bus.digits, 20'h01234);
    end while (!bus.done && n < 40);
    check("b2b_second_latency", n, 17);
    check("b2b_second_digits", bus.digits, 20'h04321);
    check("b2b_second_blank", bus.blank, 5'b10000);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_busy", bus.busy, 0);
    check("b2b_idle_done", bus.done, 0);

    // start pulsed mid-conversion is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd999;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    cap = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        cap = bus.digits;
      end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_digits", cap, 20'h01234);

    // asynchronous reset mid-conversion
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'd4321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_digits", bus.digits, 0);
    check("abort_blank", bus.blank, 5'b11110);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    convert(4321);

    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 65535)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_bcd_converter.md
# score_bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that turns the game's binary score/line count into per-digit 4-bit BCD values. It feeds the per-digit 7-segment decoders on the display path and supplies leading-zero blanking flags so unused high digits can be turned off. The core produces one result per request and holds it stable between conversions, so the display never shows partial values.

## Interface

Parameters:
- BIN_W, default 16: width of the binary input.
- DIGITS, default 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W-1. The 16/5 default pairing is legal.

Ports:
- clk  input  1  — single clock; all state changes on its rising edge.
- reset  input  1  — asynchronous, active-low reset. Assertion (0) clears state immediately. Deassertion is synchronous to clk at the board level.
- start  input  1  — conversion request; sampled only in IDLE.
- bin  input  BIN_W  — unsigned value to convert; sampled on the accepting edge only.
- busy  output  1  — high while a conversion is in progress.
- done  output  1  — one-cycle pulse when digits/blank update.
- digits  output  4*DIGITS  — BCD result; digit k (weight 10^k) is bits [4k+3:4k].
- blank  output  DIGITS  — blank[k]=1 marks digit k as a leading zero. blank[0] is always 0.

## Operation

FSM states:
- IDLE: waiting for a request.
- SHIFT: conversion running.

Working registers:
- Shift register sr of width BIN_W.
- BCD accumulator acc of width 4*DIGITS.
- Shift counter cnt, sized to count 0..BIN_W-1.

Transitions and behaviour:
- IDLE, start=1 at an edge: sr<=bin, acc<=0, cnt<=0, busy<=1, state->SHIFT.
- IDLE, start=0: no change.
- SHIFT, each edge, in a single cycle:
  - Every acc nibble >=5 gets +3. The correction is computed on the pre-shift value, all nibbles in parallel.
  - Then {acc,sr} is shifted left by 1; cnt increments.
- SHIFT, final shift (cnt==BIN_W-1):
  - The shifted accumulator value goes directly into the digits register.
  - blank is computed from that same value.
  - done<=1, busy<=0, state->IDLE.
- blank rule: blank[k]=1 iff digit k and every higher digit are 0, for k>=1. blank[0]=0 always.
  - Example: value 100 with DIGITS=5 gives blank=11000.
- start while in SHIFT is ignored; no queuing, no error.
- bin changes after the accepting edge have no effect on the running conversion.
- digits and blank hold their previous result for the whole conversion. They change only on the edge that raises done.
- Nibble arithmetic is 4-bit. Add-3 is applied only to values 5..9, so no nibble carry occurs.
- The top nibble never overflows, given the DIGITS parameter constraint.

## Timing

Reset values (while reset=0):
- state=IDLE, busy=0, done=0.
- digits=0.
- blank = all ones except blank[0]=0. For DIGITS=5 this is 11110.

Latency:
- start accepted at edge E0; busy is high from E0.
- Edges E1..E_BIN_W perform the BIN_W shifts.
- At edge E_BIN_W: digits/blank update, done=1 for exactly one cycle, busy=0.
- Default start-to-done latency is 16 cycles.

Back-to-back operation:
- start=1 during the done cycle is accepted at E_BIN_W+1.
- Sustained throughput is one result per BIN_W+1 cycles.

Reset mid-conversion:
- Aborts immediately and restores all reset values.
- No done pulse is produced; the partial result is discarded.

done and busy are never high in the same cycle.

## Test plan

- Reset, then start with bin=0 -> done exactly 16 cycles after the accepting edge; digits=0x00000, blank=11110; busy high for 16 cycles before done.
- bin=65535 -> digits=0x65535, blank=00000. bin=1234 -> digits=0x01234, blank=10000.
- bin=100 -> digits=0x00100, blank=11000 (middle zeros not blanked). bin=7 -> blank=11110.
- bin=1234 followed by start held high continuously with bin=4321 -> second conversion starts in the done cycle; second done 17 cycles after the first with digits=0x04321. digits stays 0x01234 between the two done pulses.
- Pulse start with bin=999 mid-conversion of 1234 -> ignored; result=0x01234, only one done pulse.
- Assert reset 5 cycles into a conversion of 4321 -> busy=0, digits=0, blank=11110 immediately (asynchronous); no done; a fresh start then converts normally.
